lane_write_arbiter: RTL

- Shares one packed register between two requesters. Each requester writes one lane (slice) of the register per handshake.
- The register is the datapath that the team's modport-expression interfaces expose as sub-slices.
- Conflicts (both requesters on the same lane) are resolved round-robin. Writes to different lanes commit in the same cycle.
- Sits between requester logic and the register owner.

---
 rtl/lane_write_arbiter_pkg.sv | 17 +
 rtl/rr_conflict_arb2.sv | 31 +++
 rtl/lane_write_arbiter.sv | 109 ++++++++++
 3 files changed

// File: rtl/lane_write_arbiter_pkg.sv
// Shared types and constants for the two-requester lane write arbiter.
package lane_write_arbiter_pkg;

  localparam int LANE_W_DEF  = 4;
  localparam int N_LANES_DEF = 2;

  localparam logic [7:0] CONFLICT_MAX = 8'hFF;

  typedef logic [$clog2(N_LANES_DEF)-1:0] lane_idx_t;

  typedef struct packed {
    logic                  valid;
    lane_idx_t             lane;
    logic [LANE_W_DEF-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/rr_conflict_arb2.sv
// Combinational two-way grant logic: both granted on distinct lanes, prio wins a same-lane clash.
// Zero latency; a request to an out-of-range lane is never granted.
module rr_conflict_arb2 #(
  parameter int N_LANES = 2,
  parameter int LIW     = $clog2(N_LANES)
) (
  input  logic           en,
  input  logic           valid0,
  input  logic [LIW-1:0] lane0,
  input  logic           valid1,
  input  logic [LIW-1:0] lane1,
  input  logic           prio,
  output logic           grant0,
  output logic           grant1,
  output logic           conflict
);

  localparam logic [LIW:0] LANE_LIMIT = (LIW+1)'(N_LANES);

  logic req0;
  logic req1;

  // An out-of-range lane behaves as if the requester were idle.
  assign req0 = en && valid0 && ({1'b0, lane0} < LANE_LIMIT);
  assign req1 = en && valid1 && ({1'b0, lane1} < LANE_LIMIT);

  assign conflict = req0 && req1 && (lane0 == lane1);
  assign grant0   = req0 && (!conflict || !prio);
  assign grant1   = req1 && (!conflict ||  prio);

endmodule

// File: rtl/lane_write_arbiter.sv
// Two requesters write lanes of one shared register; combinational ready, commit 1 cycle later.
// Same-lane clashes resolved round-robin; optional per-lane parity output under LANE_WRITE_ARBITER_PARITY_EN.
module lane_write_arbiter
  import lane_write_arbiter_pkg::*;
#(
  parameter int LANE_W  = LANE_W_DEF,
  parameter int N_LANES = N_LANES_DEF
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_en,
  input  logic                        i_valid0,
  output logic                        o_ready0,
  input  logic [$clog2(N_LANES)-1:0]  i_lane0,
  input  logic [LANE_W-1:0]           i_data0,
  input  logic                        i_valid1,
  output logic                        o_ready1,
  input  logic [$clog2(N_LANES)-1:0]  i_lane1,
  input  logic [LANE_W-1:0]           i_data1,
  output logic [LANE_W*N_LANES-1:0]   o_x,
  output logic [N_LANES-1:0]          o_upd,
`ifdef LANE_WRITE_ARBITER_PARITY_EN
  output logic [N_LANES-1:0]          o_parity,
`endif
  output logic [7:0]                  o_conflicts
);

  localparam int LIW = $clog2(N_LANES);
  localparam int XW  = LANE_W * N_LANES;
  localparam logic [LIW:0] LANE_LIMIT = (LIW+1)'(N_LANES);

  logic              grant0;
  logic              grant1;
  logic              conflict;
  logic              prio;
  logic [XW-1:0]     x_nxt;
  logic [N_LANES-1:0] upd_nxt;

  // Gating enable with reset keeps readys low and blocks commits during reset.
  rr_conflict_arb2 #(
    .N_LANES (N_LANES),
    .LIW     (LIW)
  ) u_arb (
    .en       (i_en && !i_rst),
    .valid0   (i_valid0),
    .lane0    (i_lane0),
    .valid1   (i_valid1),
    .lane1    (i_lane1),
    .prio     (prio),
    .grant0   (grant0),
    .grant1   (grant1),
    .conflict (conflict)
  );

  assign o_ready0 = grant0;
  assign o_ready1 = grant1;

  always_comb begin
    x_nxt   = o_x;
    upd_nxt = '0;
    for (int k = 0; k < N_LANES; k++) begin
      if (grant0 && (i_lane0 == LIW'(k))) begin
        x_nxt[k*LANE_W +: LANE_W] = i_data0;
        upd_nxt[k]                = 1'b1;
      end
      if (grant1 && (i_lane1 == LIW'(k))) begin
        x_nxt[k*LANE_W +: LANE_W] = i_data1;
        upd_nxt[k]                = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_x         <= '0;
      o_upd       <= '0;
      o_conflicts <= '0;
      prio        <= 1'b0;
    end else begin
      o_x   <= x_nxt;
      o_upd <= upd_nxt;
      if (conflict) begin
        // Point at the loser so it wins the next clash.
        prio <= grant1 ? 1'b0 : 1'b1;
        if (o_conflicts != CONFLICT_MAX) o_conflicts <= o_conflicts + 8'd1;
      end
    end
  end

`ifdef LANE_WRITE_ARBITER_PARITY_EN
  logic [N_LANES-1:0] parity_nxt;

  always_comb begin
    parity_nxt = '0;
    for (int k = 0; k < N_LANES; k++) parity_nxt[k] = ^x_nxt[k*LANE_W +: LANE_W];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) o_parity <= '0;
    else       o_parity <= parity_nxt;
  end
`endif

  a_lane0_range : assert property (@(posedge i_clk) disable iff (i_rst)
    i_valid0 |-> ({1'b0, i_lane0} < LANE_LIMIT));
  a_lane1_range : assert property (@(posedge i_clk) disable iff (i_rst)
    i_valid1 |-> ({1'b0, i_lane1} < LANE_LIMIT));

endmodule
